npu_dot_sched: RTL and testbench

Sequencer for the NPU dot-product datapath. On a start pulse it latches a job descriptor (vector length, feature and weight base addresses, bias) and streams reads from the feature and weight RAMs. It accumulates the signed products, adds the bias, and saturates the sum to an 8-bit result with a one-cycle valid pulse. It sits between the job source and the two synchronous-read RAMs inside npu_processor_top.

---
 rtl/npu_pkg.sv | 26 ++
 rtl/npu_mac_unit.sv | 52 +++++
 rtl/npu_dot_sched.sv | 115 +++++++++++
 tb/tb_npu_dot_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU dot-product scheduler.
// Holds the default widths, the scheduler state type and the saturation helper.
package npu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_BIAS_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} sched_state_t;

  typedef logic signed [DEF_DATA_W-1:0] data_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  localparam acc_t ACC_DATA_MAX = acc_t'(2**(DEF_DATA_W-1) - 1);
  localparam acc_t ACC_DATA_MIN = -acc_t'(2**(DEF_DATA_W-1));

  function automatic data_t sat_to_data(acc_t v);
    if (v > ACC_DATA_MAX)
      return data_t'(ACC_DATA_MAX);
    else if (v < ACC_DATA_MIN)
      return data_t'(ACC_DATA_MIN);
    else
      return data_t'(v);
  endfunction

endpackage

// File: rtl/npu_mac_unit.sv
// Accumulator, bias add and saturating result register for the dot scheduler.
// Define NPU_SCHED_RELU_EN to clamp negative saturated results to zero.
module npu_mac_unit
  import npu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BIAS_W = DEF_BIAS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] feat,
  input  logic signed [DATA_W-1:0] wgt,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_in;
  logic signed [ACC_W-1:0]    sum;
  data_t                      sat;

  assign prod   = feat * wgt;
  assign acc_in = acc_en ? acc_q + ACC_W'(prod) : acc_q;
  // The sum sees any product landing this cycle so the final term is never lost.
  assign sum    = acc_in + ACC_W'(bias);

  always_comb begin
    sat = sat_to_data(acc_t'(sum));
`ifdef NPU_SCHED_RELU_EN
    if (sat[DEF_DATA_W-1])
      sat = '0;
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      result <= '0;
    end else begin
      acc_q <= clr ? '0 : acc_in;
      if (load)
        result <= DATA_W'(sat);
    end
  end

endmodule

// File: rtl/npu_dot_sched.sv
// Dot-product job sequencer: latches a descriptor, streams RAM reads, emits a saturated result.
// Optional NPU_SCHED_RELU_EN (handled in npu_mac_unit) clamps negative results to zero.
module npu_dot_sched
  import npu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int BIAS_W = DEF_BIAS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         vec_len,
  input  logic [ADDR_W-1:0]        feat_base,
  input  logic [ADDR_W-1:0]        wgt_base,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     busy,
  output logic                     feat_rd_en,
  output logic [ADDR_W-1:0]        feat_addr,
  input  logic signed [DATA_W-1:0] feat_rd_data,
  output logic                     wgt_rd_en,
  output logic [ADDR_W-1:0]        wgt_addr,
  input  logic signed [DATA_W-1:0] wgt_rd_data,
  output logic signed [DATA_W-1:0] result_out,
  output logic                     result_valid
);

  sched_state_t             state_q, next_state;
  logic [LEN_W-1:0]         idx_q, len_q;
  logic [ADDR_W-1:0]        feat_base_q, wgt_base_q;
  logic signed [BIAS_W-1:0] bias_q;
  logic                     rd_valid_q;
  logic                     rd_en, acc_clr, load;

  // RUN holds one extra cycle with strobes low (idx == len) so the last read can land.
  assign rd_en        = (state_q == RUN) && (idx_q != len_q);
  assign feat_rd_en   = rd_en;
  assign wgt_rd_en    = rd_en;
  assign feat_addr    = rd_en ? feat_base_q + ADDR_W'(idx_q) : '0;
  assign wgt_addr     = rd_en ? wgt_base_q + ADDR_W'(idx_q) : '0;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    acc_clr    = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr    = 1'b1;
          next_state = (vec_len == '0) ? FINAL : RUN;
        end
      end
      RUN: begin
        if (idx_q == len_q)
          next_state = FINAL;
      end
      FINAL: begin
        load       = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      len_q       <= '0;
      feat_base_q <= '0;
      wgt_base_q  <= '0;
      bias_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (state_q == IDLE && start) begin
        idx_q       <= '0;
        len_q       <= vec_len;
        feat_base_q <= feat_base;
        wgt_base_q  <= wgt_base;
        bias_q      <= bias;
      end else if (rd_en) begin
        idx_q <= idx_q + LEN_W'(1);
      end
    end
  end

  npu_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .BIAS_W (BIAS_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .acc_en (rd_valid_q),
    .load   (load),
    .feat   (feat_rd_data),
    .wgt    (wgt_rd_data),
    .bias   (bias_q),
    .result (result_out)
  );

endmodule

// File: tb/tb_npu_dot_sched.sv
// Self-checking bench for npu_dot_sched with behavioural RAMs and a dot-product reference model.
// Expected results follow NPU_SCHED_RELU_EN when it is defined.
module tb_npu_dot_sched;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        vec_len = '0;
  logic [7:0]        feat_base = '0;
  logic [7:0]        wgt_base = '0;
  logic signed [15:0] bias = '0;
  logic              busy, feat_rd_en, wgt_rd_en, result_valid;
  logic [7:0]        feat_addr, wgt_addr;
  logic signed [7:0] feat_rd_data, wgt_rd_data, result_out;

  logic signed [7:0] feat_mem [256];
  logic signed [7:0] wgt_mem  [256];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  npu_dot_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_len      (vec_len),
    .feat_base    (feat_base),
    .wgt_base     (wgt_base),
    .bias         (bias),
    .busy         (busy),
    .feat_rd_en   (feat_rd_en),
    .feat_addr    (feat_addr),
    .feat_rd_data (feat_rd_data),
    .wgt_rd_en    (wgt_rd_en),
    .wgt_addr     (wgt_addr),
    .wgt_rd_data  (wgt_rd_data),
    .result_out   (result_out),
    .result_valid (result_valid)
  );

  // Synchronous-read RAM models: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (feat_rd_en) feat_rd_data <= feat_mem[feat_addr];
    if (wgt_rd_en)  wgt_rd_data  <= wgt_mem[wgt_addr];
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int expected_result(int len, int fb, int wb, int b);
    longint s = b;
    for (int k = 0; k < len; k++)
      s += longint'(feat_mem[(fb + k) % 256]) * longint'(wgt_mem[(wb + k) % 256]);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef NPU_SCHED_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  task automatic run_job(input string name, input int len, input int fb, input int wb, input int b,
                         input int inj_cycle, input bit start_in_done);
    int exp;
    int vcyc;
    exp  = expected_result(len, fb, wb, b);
    vcyc = (len == 0) ? 2 : len + 3;
    @(posedge clk); #1;
    check({name, ":idle_before"}, busy, 0);
    check({name, ":no_valid_idle"}, result_valid, 0);
    start     = 1'b1;
    vec_len   = 8'(len);
    feat_base = 8'(fb);
    wgt_base  = 8'(wb);
    bias      = 16'(b);
    for (int c = 1; c <= vcyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == inj_cycle) begin
        start     = 1'b1;
        vec_len   = 8'($urandom_range(1, 9));
        feat_base = 8'($urandom);
        wgt_base  = 8'($urandom);
        bias      = 16'($urandom);
      end
      check($sformatf("%s:busy@%0d", name, c), busy, 1);
      check($sformatf("%s:feat_en@%0d", name, c), feat_rd_en, (c <= len) ? 1 : 0);
      check($sformatf("%s:wgt_en@%0d", name, c), wgt_rd_en, (c <= len) ? 1 : 0);
      if (c <= len) begin
        check($sformatf("%s:feat_addr@%0d", name, c), feat_addr, (fb + c - 1) % 256);
        check($sformatf("%s:wgt_addr@%0d", name, c), wgt_addr, (wb + c - 1) % 256);
      end
      check($sformatf("%s:valid@%0d", name, c), result_valid, (c == vcyc) ? 1 : 0);
    end
    check({name, ":result"}, result_out, exp);
    if (start_in_done) start = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      feat_mem[i] = 8'($urandom);
      wgt_mem[i]  = 8'($urandom);
    end
    feat_mem[0] = 10;  feat_mem[1] = 5;  feat_mem[2] = 2;
    wgt_mem[0]  = 2;   wgt_mem[1]  = -3; wgt_mem[2]  = 4;
    for (int i = 16; i < 20; i++) begin
      feat_mem[i] = 127;
      wgt_mem[i]  = 127;
    end
    for (int i = 32; i < 36; i++) wgt_mem[i] = -128;

    $display("[TB] reset check");
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", busy, 0);
    check("rst:feat_en", feat_rd_en, 0);
    check("rst:wgt_en", wgt_rd_en, 0);
    check("rst:feat_addr", feat_addr, 0);
    check("rst:wgt_addr", wgt_addr, 0);
    check("rst:result", result_out, 0);
    check("rst:valid", result_valid, 0);
    rst = 1'b0;

    $display("[TB] directed jobs");
    check("basic:model", expected_result(3, 0, 0, 5), 18);
    run_job("basic", 3, 0, 0, 5, 0, 1'b1);
    run_job("after_done", 4, 16, 16, 0, 0, 1'b0);
    run_job("sat_neg", 4, 16, 32, 0, 0, 1'b0);
    run_job("zero_len", 0, 0, 0, -7, 0, 1'b0);
    run_job("wrap", 3, 254, 100, 33, 0, 1'b0);
    run_job("busy_ignore", 3, 0, 0, 5, 2, 1'b0);

    $display("[TB] reset mid-job");
    @(posedge clk); #1;
    start = 1'b1; vec_len = 8'd3; feat_base = 8'd0; wgt_base = 8'd0; bias = 16'sd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst:feat_en", feat_rd_en, 0);
    check("midrst:wgt_en", wgt_rd_en, 0);
    check("midrst:busy", busy, 0);
    check("midrst:result", result_out, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst:valid@%0d", c), result_valid, 0);
    end
    rst = 1'b0;
    run_job("post_rst", 3, 0, 0, 5, 0, 1'b0);

    $display("[TB] random jobs");
    for (int i = 0; i < 8; i++) begin
      int rl, rf, rw;
      logic signed [15:0] rb;
      rl = $urandom_range(0, 24);
      rf = $urandom_range(0, 255);
      rw = $urandom_range(0, 255);
      rb = 16'($urandom_range(0, 65535));
      run_job($sformatf("rand%0d", i), rl, rf, rw, int'(rb), 0, 1'b0);
    end

    @(posedge clk); #1;
    check("final:idle", busy, 0);
    check("final:no_valid", result_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
